// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle add/subtract, one DIGIT-bit slice per cycle, LSB first,
// with the borrow/carry registered between slices and a start/busy/done handshake.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, res;
  logic [DIGIT-1:0] as, bs;
  logic [DIGIT:0] s;
  logic [CW-1:0] cnt;
  logic mode_r, br, last;
  always_comb begin
    as = a_r[cnt*DIGIT +: DIGIT];
    bs = b_r[cnt*DIGIT +: DIGIT];
    s = mode_r ? {1'b0, as} + {1'b0, bs} + {{DIGIT{1'b0}}, br}
               : {1'b0, as} - {1'b0, bs} - {{DIGIT{1'b0}}, br};
    res = diff;
    res[cnt*DIGIT +: DIGIT] = s[DIGIT-1:0];
    last = cnt == LAST;
  end
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      mode_r <= 1'b0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      mode_r <= mode;
      br <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      diff <= res;
      br <= s[DIGIT];
      if (last) begin
        bout <= s[DIGIT];
        // signs differ for sub / agree for add, and the result sign left a's sign
        ovf <= (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ mode_r) & (res[WIDTH-1] ^ a_r[WIDTH-1]);
        zero <= res == '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed and random checks of three digit sizes (1, 4, 16)
// driven in lockstep, comparing results, flags, done latency and busy length.
module tb_digit_serial_addsub;
  logic clk = 0, rst = 1, start = 0, mode = 0, bin = 0;
  logic [15:0] a = '0, b = '0;
  logic busy_w [3], done_w [3], bout_w [3], ovf_w [3], zero_w [3];
  logic [15:0] diff_w [3];
  int ncyc = 0, errors = 0, checks = 0;
  int ndone [3] = '{0, 0, 0};
  int nbusy [3] = '{0, 0, 0};
  int tdone [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .bin(bin), .busy(busy_w[0]), .done(done_w[0]), .diff(diff_w[0]),
    .bout(bout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .bin(bin), .busy(busy_w[1]), .done(done_w[1]), .diff(diff_w[1]),
    .bout(bout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]));
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u16 (.clk(clk), .rst(rst), .start(start), .mode(mode),
    .a(a), .b(b), .bin(bin), .busy(busy_w[2]), .done(done_w[2]), .diff(diff_w[2]),
    .bout(bout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]));

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (done_w[k]) begin
        ndone[k] <= ndone[k] + 1;
        tdone[k] <= ncyc + 1;
      end
      if (busy_w[k]) nbusy[k] <= nbusy[k] + 1;
    end
  end

  function automatic int nd(input int k);
    return k == 0 ? 16 : k == 1 ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ndig=%0d observed=%0h expected=%0h", tag, nd(k), obs, exp);
    end
  endtask

  function automatic logic [18:0] model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                        input logic bi);
    logic [16:0] r;
    logic ov;
    r = m ? {1'b0, x} + {1'b0, y} + {16'b0, bi} : {1'b0, x} - {1'b0, y} - {16'b0, bi};
    ov = m ? (x[15] == y[15] && r[15] != x[15]) : (x[15] != y[15] && r[15] != x[15]);
    return {r[15:0] == 16'h0, ov, r[16], r[15:0]};
  endfunction

  task automatic op(input logic m, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                    input logic [15:0] ed, input logic eb, input logic eo, input logic ez, input bit ign);
    int s;
    int d0 [3];
    int b0 [3];
    @(negedge clk); #1;
    mode = m; a = av; b = bv; bin = bi; start = 1; s = ncyc;
    for (int k = 0; k < 3; k++) begin
      d0[k] = ndone[k];
      b0[k] = nbusy[k];
    end
    @(negedge clk); #1;
    start = 0; a = ~av; b = 16'($urandom); mode = ~m; bin = ~bi;
    if (ign) begin
      @(negedge clk); #1;
      start = 1;
      @(negedge clk); #1;
      start = 0;
    end
    while (ncyc < s + 20) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("done_count", k, ndone[k] - d0[k], 1);
      chk("done_cycle", k, tdone[k], s + nd(k) + 1);
      chk("busy_cycles", k, nbusy[k] - b0[k], nd(k) + 1);
      chk("diff", k, {16'b0, diff_w[k]}, {16'b0, ed});
      chk("bout", k, {31'b0, bout_w[k]}, {31'b0, eb});
      chk("ovf", k, {31'b0, ovf_w[k]}, {31'b0, eo});
      chk("zero", k, {31'b0, zero_w[k]}, {31'b0, ez});
    end
  endtask

  initial begin
    int d0 [3];
    logic [18:0] e;
    logic [15:0] ra, rb;
    logic rm, rbi;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", k, {31'b0, busy_w[k]}, 0);
      chk("reset_done", k, {31'b0, done_w[k]}, 0);
      chk("reset_out", k, {12'b0, diff_w[k], bout_w[k], ovf_w[k], zero_w[k]}, 0);
    end
    rst = 0;
    op(0, 16'h1234, 16'h0235, 0, 16'h0FFF, 0, 0, 0, 0);
    op(0, 16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0, 0);
    @(negedge clk); #1;
    mode = 0; a = 16'h4444; b = 16'h1111; bin = 0; start = 1;
    @(negedge clk); #1;
    start = 0; rst = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      d0[k] = ndone[k];
      chk("abort_busy", k, {31'b0, busy_w[k]}, 0);
      chk("abort_out", k, {12'b0, diff_w[k], bout_w[k], ovf_w[k], zero_w[k]}, 0);
    end
    @(negedge clk); #1;
    rst = 0;
    repeat (20) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("abort_no_done", k, ndone[k] - d0[k], 0);
    op(0, 16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, 0, 0);
    op(0, 16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0, 0, 0);
    op(0, 16'h0005, 16'h0005, 0, 16'h0000, 0, 0, 1, 0);
    op(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, 0);
    op(1, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, 0);
    op(1, 16'h1234, 16'h4321, 1, 16'h5556, 0, 0, 0, 0);
    op(0, 16'h1234, 16'h0235, 0, 16'h0FFF, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom); rbi = 1'($urandom);
      e = model(rm, ra, rb, rbi);
      op(rm, ra, rb, rbi, e[15:0], e[16], e[17], e[18], 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
